// File: rtl/comparador_serial_i_d_pkg.sv
// Shared types for the MSB-first serial comparator.
// State encoding and counter sizing helper.
package comparador_serial_i_d_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } estado_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comparador_serial_i_d_celda.sv
// One-bit decision cell, combinational.
// Gate-level, same style as the right-to-left cell chain.
module celda_decision_i_d (
  input  logic a_bit,
  input  logic b_bit,
  output logic mayor,
  output logic menor,
  output logic igual
);

  wire na;
  wire nb;

  not u_na (na, a_bit);
  not u_nb (nb, b_bit);
  and u_my (mayor, a_bit, nb);
  and u_mn (menor, na, b_bit);
  xnor u_ig (igual, a_bit, b_bit);

endmodule

// File: rtl/comparador_serial_i_d.sv
// Bit-serial magnitude comparator, MSB first.
// Exits at the first differing bit or after N equal bits.
module comparador_serial_i_d
  import comparador_serial_i_d_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a_p,
  input  logic [N-1:0] b_p,
  output logic         busy,
  output logic         done,
  output logic         a_mayor,
  output logic         a_menor,
  output logic         iguales
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  estado_t       st;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [CW-1:0] cnt;
  logic          c_may;
  logic          c_men;
  logic          c_ig;

  celda_decision_i_d u_celda (
    .a_bit (sa[N-1]),
    .b_bit (sb[N-1]),
    .mayor (c_may),
    .menor (c_men),
    .igual (c_ig)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_mayor <= 1'b0;
      a_menor <= 1'b0;
      iguales <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE, DONE: begin
          // DONE accepts start too, for back-to-back compares
          if (start) begin
            sa      <= a_p;
            sb      <= b_p;
            cnt     <= '0;
            a_mayor <= 1'b0;
            a_menor <= 1'b0;
            iguales <= 1'b0;
            busy    <= 1'b1;
            st      <= CMP;
          end else begin
            busy <= 1'b0;
            st   <= IDLE;
          end
        end
        CMP: begin
          if (!c_ig) begin
            a_mayor <= c_may;
            a_menor <= c_men;
            busy    <= 1'b0;
            done    <= 1'b1;
            st      <= DONE;
          end else if (cnt == CNT_LAST) begin
            iguales <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            st      <= DONE;
          end else begin
            sa  <= sa << 1;
            sb  <= sb << 1;
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy <= 1'b0;
          st   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_serial_i_d.sv
// Scoreboard bench for the MSB-first serial comparator.
// Reference: integer compare plus first-differing-bit latency.
module tb_comparador_serial_i_d;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_p = '0;
  logic [7:0] b_p = '0;
  logic       busy, done, a_mayor, a_menor, iguales;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1, done1, may1, men1, ig1;

  comparador_serial_i_d #(.N(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_p(a_p), .b_p(b_p),
    .busy(busy), .done(done),
    .a_mayor(a_mayor), .a_menor(a_menor), .iguales(iguales)
  );

  comparador_serial_i_d #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a_p(a1), .b_p(b1),
    .busy(busy1), .done(done1),
    .a_mayor(may1), .a_menor(men1), .iguales(ig1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] flags;
    int         due;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   next_ok = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // cycles from accepting edge to done: position of first differing bit
  function automatic int lat8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    x = a ^ b;
    for (int i = 7; i >= 0; i--)
      if (x[i]) return 8 - i;
    return 8;
  endfunction

  // reference model: decides acceptance and predicts result/timing
  always @(posedge clk) begin
    exp_t e;
    if (!rst && start && cyc >= next_ok) begin
      e.flags = {a_p > b_p, a_p < b_p, a_p == b_p};
      e.lat   = lat8(a_p, b_p);
      e.due   = cyc + e.lat + 1;
      q.push_back(e);
      next_ok = cyc + e.lat + 1;
    end
    cyc++;
  end

  always @(posedge rst) begin
    q.delete();
    next_ok = 0;
  end

  // monitor
  always @(negedge clk) begin
    exp_t e;
    int   exp_busy;
    if (!rst) begin
      exp_busy = (q.size() > 0 && cyc < q[0].due) ? 1 : 0;
      check("busy", int'(busy), exp_busy);
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("done_cycle", cyc, e.due);
          check("flags", int'({a_mayor, a_menor, iguales}), int'(e.flags));
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        e = q.pop_front();
        check("missed_done", 0, 1);
      end
    end
  end

  task automatic wait_empty();
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    a_p = a;
    b_p = b;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
  endtask

  logic [7:0] pa[3];
  logic [7:0] pb[3];
  logic [7:0] ra, rb;
  int idx;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_outs", int'({busy, done, a_mayor, a_menor, iguales}), 0);
    check("rst_outs1", int'({busy1, done1, may1, men1, ig1}), 0);
    rst = 1'b0;

    // abort a compare with asynchronous reset
    @(negedge clk);
    start = 1'b1;
    a_p = 8'h12;
    b_p = 8'h13;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async", int'({busy, done, a_mayor, a_menor, iguales}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    run(8'h80, 8'h7F);
    run(8'h12, 8'h13);
    run(8'hA5, 8'hA5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("flag_hold", int'({a_mayor, a_menor, iguales}), 1);
    end
    @(negedge clk);
    start = 1'b1;
    a_p = 8'h3C;
    b_p = 8'h3C;
    @(posedge clk);
    #1 check("flag_clear", int'({busy, a_mayor, a_menor, iguales}), 8);
    @(negedge clk);
    start = 1'b0;
    wait_empty();

    // start held high; junk inputs during CMP, chained DONE accepts
    ra = 8'($urandom);
    rb = 8'($urandom);
    pa[0] = ra; pb[0] = rb;
    pa[1] = 8'h40; pb[1] = 8'h20;
    pa[2] = 8'h01; pb[2] = 8'h02;
    idx = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cyc >= next_ok) begin
        if (idx < 3) begin
          start = 1'b1;
          a_p = pa[idx];
          b_p = pb[idx];
          idx++;
        end else begin
          start = 1'b0;
          break;
        end
      end else begin
        start = 1'b1;
        a_p = 8'($urandom);
        b_p = 8'($urandom);
      end
    end
    start = 1'b0;
    wait_empty();

    // random compares, biased toward near-equal operands
    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: rb = ra ^ (8'd1 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      run(ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // N=1 corner
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start1 = 1'b1;
      a1 = (k == 0) ? 1'b0 : 1'b1;
      b1 = (k == 1) ? 1'b0 : 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("n1_busy", int'({busy1, done1}), 2);
      @(negedge clk);
      check("n1_done", int'({busy1, done1}), 1);
      check("n1_flags", int'({may1, men1, ig1}),
            (k == 0) ? 2 : ((k == 1) ? 4 : 1));
    end

    repeat (2) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
